// File: rtl/shared_round_key_buffer.sv
// Captures two-share round keys from shared_key_expansion into separate register banks
// and serves them to the masked round function in ascending or descending order.
module shared_round_key_buffer #(
    parameter int ROUNDS = 16,
    parameter int KW     = 128
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          key_load,
    output logic          key_exp_ena,
    input  logic [KW-1:0] full_round_key_q0,
    input  logic [KW-1:0] full_round_key_q1,
    input  logic [4:0]    key_exp_round_cnt,
    input  logic          key_exp_occupied,
    output logic          keys_valid,
    output logic          key_err,
    input  logic          rk_restart,
    input  logic          rk_dir,
    input  logic          rk_req,
    output logic [KW-1:0] rk0,
    output logic [KW-1:0] rk1,
    output logic [4:0]    rk_idx,
    output logic          rk_valid,
    output logic          rk_last,
    output logic [2:0]    fsm_state
);

    localparam int NK = ROUNDS + 1;
    localparam logic [4:0] LAST_IDX = 5'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_CAPTURE   = 3'd3,
        S_READY     = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2:0]    wait_cnt;
    logic [NK-1:0] mask;
    logic          mask_full;
    logic          cnt_ok;

    logic clear_flags;
    logic cap_en;
    logic timeout;
    logic cap_done_ok;
    logic cap_done_bad;
    logic serve_en;

    logic [KW-1:0] bank0 [NK];
    logic [KW-1:0] bank1 [NK];

    logic [4:0] ptr;
    logic       dir_q;
    logic [4:0] start_idx;
    logic       eff_dir;
    logic [4:0] eff_idx;
    logic       is_last;
    logic [4:0] wrap_idx;
    logic [4:0] step_idx;

    assign mask_full = &mask;
    assign cnt_ok    = (key_exp_round_cnt <= LAST_IDX);
    assign fsm_state = state;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (key_load) state_nxt = S_REQ;
            end
            S_REQ: begin
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (key_exp_occupied) state_nxt = S_CAPTURE;
                else if (wait_cnt == 3'd7) state_nxt = S_IDLE;
            end
            S_CAPTURE: begin
                if (!key_exp_occupied) state_nxt = mask_full ? S_READY : S_IDLE;
            end
            S_READY: begin
                if (key_load) state_nxt = S_REQ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / controls ----------------
    always_comb begin
        key_exp_ena  = 1'b0;
        clear_flags  = 1'b0;
        cap_en       = 1'b0;
        timeout      = 1'b0;
        cap_done_ok  = 1'b0;
        cap_done_bad = 1'b0;
        serve_en     = 1'b0;
        case (state)
            S_REQ: begin
                key_exp_ena = 1'b1;
                clear_flags = 1'b1;
            end
            S_WAIT_BUSY: begin
                cap_en  = key_exp_occupied && cnt_ok;
                timeout = !key_exp_occupied && (wait_cnt == 3'd7);
            end
            S_CAPTURE: begin
                cap_en       = key_exp_occupied && cnt_ok;
                cap_done_ok  = !key_exp_occupied && mask_full;
                cap_done_bad = !key_exp_occupied && !mask_full;
            end
            S_READY: begin
                serve_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Counts idle cycles spent waiting for the expansion to report busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= 3'd0;
        end else if (state == S_WAIT_BUSY) begin
            wait_cnt <= wait_cnt + 3'd1;
        end else begin
            wait_cnt <= 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask       <= '0;
            keys_valid <= 1'b0;
            key_err    <= 1'b0;
        end else if (clear_flags) begin
            mask       <= '0;
            keys_valid <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            if (cap_en) mask[key_exp_round_cnt] <= 1'b1;
            if (cap_done_ok) keys_valid <= 1'b1;
            if (cap_done_bad) keys_valid <= 1'b0;
            if (timeout || cap_done_bad) key_err <= 1'b1;
        end
    end

    // Share banks are written and read on fully separate paths.
    always_ff @(posedge clk) begin
        if (cap_en) bank0[key_exp_round_cnt] <= full_round_key_q0;
    end

    always_ff @(posedge clk) begin
        if (cap_en) bank1[key_exp_round_cnt] <= full_round_key_q1;
    end

    // Read port: rk_req is accepted only in READY with no backpressure; the key appears
    // one cycle later qualified by the single-cycle rk_valid strobe and then holds.
    assign start_idx = rk_dir ? LAST_IDX : 5'd0;
    assign eff_dir   = rk_restart ? rk_dir : dir_q;
    assign eff_idx   = rk_restart ? start_idx : ptr;
    assign is_last   = eff_dir ? (eff_idx == 5'd0) : (eff_idx == LAST_IDX);
    assign wrap_idx  = eff_dir ? LAST_IDX : 5'd0;
    assign step_idx  = is_last ? wrap_idx : (eff_dir ? eff_idx - 5'd1 : eff_idx + 5'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr      <= 5'd0;
            dir_q    <= 1'b0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            rk_idx   <= 5'd0;
        end else begin
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            if (serve_en && rk_restart) begin
                dir_q <= rk_dir;
                ptr   <= start_idx;
            end
            if (serve_en && rk_req) begin
                rk_valid <= 1'b1;
                rk_last  <= is_last;
                rk_idx   <= eff_idx;
                ptr      <= step_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rk0 <= '0;
        end else if (serve_en && rk_req) begin
            rk0 <= bank0[eff_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rk1 <= '0;
        end else if (serve_en && rk_req) begin
            rk1 <= bank1[eff_idx];
        end
    end

endmodule
